// File: rtl/vc_miss_sequencer_pkg.sv
// vc_pkg: shared types and constants for the victim-cache miss sequencer.
//   vc_seq_state_t : miss sequencer FSM encoding
//   VcOffset/VcLine: default line geometry shared with the victim cache
//   line_align()   : clears the line-offset bits of a byte address
package vc_pkg;

   localparam int unsigned VcOffset = 5;
   localparam int unsigned VcLine   = 8 * (2 ** VcOffset);

   typedef enum logic [2:0] {
      StIdle,
      StProbe,
      StMemRd,
      StVcWr,
      StResp
   } vc_seq_state_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned offset);
      return addr & (32'hFFFF_FFFF << offset);
   endfunction

endpackage

// File: rtl/vc_miss_sequencer_if.sv
// vc_miss_sequencer_if: L1 miss, victim cache and physical-memory signals of the sequencer.
//   master : the sequencer side (takes L1 requests, issues vc/pmem commands)
//   slave  : the surrounding system (L1 control, victim cache, memory)
interface vc_miss_sequencer_if
   import vc_pkg::*;
#(
   parameter int unsigned LineW = VcLine
);
   // L1 control
   logic              l1_req;
   logic [31:0]       l1_addr;
   logic              l1_evict;
   logic [31:0]       l1_evict_addr;
   logic [LineW-1:0]  l1_evict_data;
   logic              l1_evict_dirty;
   logic              l1_resp;
   logic [LineW-1:0]  l1_rdata;
   logic              l1_from_vc;
   // Victim cache
   logic              vc_read;
   logic              vc_write;
   logic [31:0]       vc_mem_address;
   logic [LineW-1:0]  vc_mem_wdata;
   logic              vc_is_dirty;
   logic [LineW-1:0]  vc_rdata;
   logic              vc_rdata_exists;
   // Physical memory
   logic              pmem_read;
   logic [31:0]       pmem_address;
   logic [LineW-1:0]  pmem_rdata;
   logic              pmem_resp;

   modport master (
      input  l1_req, l1_addr, l1_evict, l1_evict_addr, l1_evict_data, l1_evict_dirty,
      output l1_resp, l1_rdata, l1_from_vc,
      output vc_read, vc_write, vc_mem_address, vc_mem_wdata, vc_is_dirty,
      input  vc_rdata, vc_rdata_exists,
      output pmem_read, pmem_address,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      output l1_req, l1_addr, l1_evict, l1_evict_addr, l1_evict_data, l1_evict_dirty,
      input  l1_resp, l1_rdata, l1_from_vc,
      input  vc_read, vc_write, vc_mem_address, vc_mem_wdata, vc_is_dirty,
      output vc_rdata, vc_rdata_exists,
      input  pmem_read, pmem_address,
      output pmem_rdata, pmem_resp
   );

endinterface

// File: rtl/vc_miss_sequencer_sat_counter.sv
// vc_sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count
module vc_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/vc_miss_sequencer.sv
// vc_miss_sequencer: runs one L1 miss through victim-cache probe, optional memory read,
// victim write-back into the victim cache and the L1 fill response.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   bus_io          : L1 / victim cache / memory signals (vc_miss_sequencer_if.master)
//   stat_hits_o     : saturating victim-cache hit count
//   stat_misses_o   : saturating victim-cache miss count
module vc_miss_sequencer
   import vc_pkg::*;
#(
   parameter int unsigned s_offset  = VcOffset,
   parameter int unsigned s_line    = 8 * (2 ** s_offset),
   parameter int unsigned PROBE_TMO = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   vc_miss_sequencer_if.master bus_io,
   output logic [CNT_W-1:0]    stat_hits_o,
   output logic [CNT_W-1:0]    stat_misses_o
);

   localparam int unsigned TmoW = $clog2(PROBE_TMO + 1);

   vc_seq_state_t     state_q, state_d;
   logic [TmoW-1:0]   cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              evict_q, evict_d;
   logic [31:0]       ev_addr_q, ev_addr_d;
   logic [s_line-1:0] ev_data_q, ev_data_d;
   logic              ev_dirty_q, ev_dirty_d;
   logic [s_line-1:0] line_q, line_d;
   logic              from_vc_q, from_vc_d;
   logic              vc_read_q, vc_read_d;
   logic              vc_write_q, vc_write_d;
   logic              pmem_read_q, pmem_read_d;
   logic              l1_resp_q, l1_resp_d;
   logic [31:0]       vc_addr_q, vc_addr_d;
   logic [31:0]       pmem_addr_q, pmem_addr_d;
   logic              hit_inc, miss_inc;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      evict_d    = evict_q;
      ev_addr_d  = ev_addr_q;
      ev_data_d  = ev_data_q;
      ev_dirty_d = ev_dirty_q;
      line_d     = line_q;
      from_vc_d  = from_vc_q;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.l1_req) begin
               addr_d     = line_align(bus_io.l1_addr, s_offset);
               evict_d    = bus_io.l1_evict;
               ev_addr_d  = line_align(bus_io.l1_evict_addr, s_offset);
               ev_data_d  = bus_io.l1_evict_data;
               ev_dirty_d = bus_io.l1_evict_dirty;
               cnt_d      = TmoW'(1);
               state_d    = StProbe;
            end
         end
         StProbe: begin
            // A hit in the timeout cycle still counts as a hit.
            if (bus_io.vc_rdata_exists) begin
               line_d    = bus_io.vc_rdata;
               from_vc_d = 1'b1;
               hit_inc   = 1'b1;
               state_d   = evict_q ? StVcWr : StResp;
            end else if (cnt_q == TmoW'(PROBE_TMO)) begin
               miss_inc = 1'b1;
               state_d  = StMemRd;
            end else begin
               cnt_d = cnt_q + TmoW'(1);
            end
         end
         StMemRd: begin
            if (bus_io.pmem_resp) begin
               line_d    = bus_io.pmem_rdata;
               from_vc_d = 1'b0;
               state_d   = evict_q ? StVcWr : StResp;
            end
         end
         StVcWr: begin
            if (bus_io.vc_rdata_exists) begin
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Commands are decoded from the next state so they are registered and line up with it.
      vc_read_d   = (state_d == StProbe);
      vc_write_d  = (state_d == StVcWr);
      pmem_read_d = (state_d == StMemRd);
      l1_resp_d   = (state_d == StResp);
      vc_addr_d   = vc_read_d ? addr_d : (vc_write_d ? ev_addr_d : 32'd0);
      pmem_addr_d = pmem_read_d ? addr_d : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         evict_q     <= 1'b0;
         ev_addr_q   <= '0;
         ev_data_q   <= '0;
         ev_dirty_q  <= 1'b0;
         line_q      <= '0;
         from_vc_q   <= 1'b0;
         vc_read_q   <= 1'b0;
         vc_write_q  <= 1'b0;
         pmem_read_q <= 1'b0;
         l1_resp_q   <= 1'b0;
         vc_addr_q   <= '0;
         pmem_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         evict_q     <= evict_d;
         ev_addr_q   <= ev_addr_d;
         ev_data_q   <= ev_data_d;
         ev_dirty_q  <= ev_dirty_d;
         line_q      <= line_d;
         from_vc_q   <= from_vc_d;
         vc_read_q   <= vc_read_d;
         vc_write_q  <= vc_write_d;
         pmem_read_q <= pmem_read_d;
         l1_resp_q   <= l1_resp_d;
         vc_addr_q   <= vc_addr_d;
         pmem_addr_q <= pmem_addr_d;
      end
   end

   vc_sat_counter #(
      .CNT_W (CNT_W)
   ) u_hit_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (hit_inc),
      .count_o (stat_hits_o)
   );

   vc_sat_counter #(
      .CNT_W (CNT_W)
   ) u_miss_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (miss_inc),
      .count_o (stat_misses_o)
   );

   assign bus_io.l1_resp        = l1_resp_q;
   assign bus_io.l1_rdata       = line_q;
   assign bus_io.l1_from_vc     = from_vc_q;
   assign bus_io.vc_read        = vc_read_q;
   assign bus_io.vc_write       = vc_write_q;
   assign bus_io.vc_mem_address = vc_addr_q;
   // Victim data only shows on the bus while the write command is up.
   assign bus_io.vc_mem_wdata   = vc_write_q ? ev_data_q : '0;
   assign bus_io.vc_is_dirty    = vc_write_q & ev_dirty_q;
   assign bus_io.pmem_read      = pmem_read_q;
   assign bus_io.pmem_address   = pmem_addr_q;

endmodule

// File: tb/tb_vc_miss_sequencer.sv
// Directed bench for vc_miss_sequencer: scoreboard of expected fills plus immediate asserts.
module tb_vc_miss_sequencer;
   import vc_pkg::*;

   typedef struct packed {
      logic [255:0] line;
      logic         from_vc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        sat_inc;
   logic [15:0] sat_count;
   logic [15:0] stat_hits;
   logic [15:0] stat_misses;
   int          checks;
   int          errors;
   exp_t        sb_q[$];

   vc_miss_sequencer_if bus ();

   vc_miss_sequencer dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus_io        (bus),
      .stat_hits_o   (stat_hits),
      .stat_misses_o (stat_misses)
   );

   vc_sat_counter #(
      .CNT_W (16)
   ) u_sat (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .inc_i   (sat_inc),
      .count_o (sat_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_resp(input int budget);
      bit   seen;
      exp_t e;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (bus.l1_resp === 1'b1) seen = 1'b1;
         else step();
      end
      chk("resp_seen", 256'(seen), 256'(1));
      if (seen) begin
         if (sb_q.size() == 0) begin
            chk("sb_nonempty", 256'(0), 256'(1));
         end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", bus.l1_rdata, e.line);
            chk("resp_from_vc", 256'(bus.l1_from_vc), 256'(e.from_vc));
         end
         bus.l1_req = 1'b0;
         step();
         chk("resp_one_cycle", 256'(bus.l1_resp), 256'(0));
      end
   endtask

   initial begin
      bit          any_resp;
      logic [31:0] v32;
      checks = 0;
      errors = 0;
      sat_inc = 1'b0;
      bus.l1_req = 1'b1;
      bus.l1_addr = 32'h1000_0044;
      bus.l1_evict = 1'b0;
      bus.l1_evict_addr = '0;
      bus.l1_evict_data = '0;
      bus.l1_evict_dirty = 1'b0;
      bus.vc_rdata = '0;
      bus.vc_rdata_exists = 1'b0;
      bus.pmem_rdata = '0;
      bus.pmem_resp = 1'b0;
      rst_n = 1'b0;

      // 1. Reset held with a pending request: everything stays zero.
      repeat (3) step();
      chk("rst_vc_read", 256'(bus.vc_read), 256'(0));
      chk("rst_vc_write", 256'(bus.vc_write), 256'(0));
      chk("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
      chk("rst_l1_resp", 256'(bus.l1_resp), 256'(0));
      chk("rst_vc_addr", 256'(bus.vc_mem_address), 256'(0));
      chk("rst_pmem_addr", 256'(bus.pmem_address), 256'(0));
      chk("rst_l1_rdata", bus.l1_rdata, 256'(0));
      chk("rst_hits", 256'(stat_hits), 256'(0));
      chk("rst_misses", 256'(stat_misses), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_no_probe_yet", 256'(bus.vc_read), 256'(0));

      // 2. Hit after two probe cycles, no victim.
      sb_q.push_back('{line: {32{8'hA5}}, from_vc: 1'b1});
      step();
      chk("t2_vc_read", 256'(bus.vc_read), 256'(1));
      chk("t2_vc_addr", 256'(bus.vc_mem_address), 256'(32'h1000_0040));
      step();
      bus.vc_rdata = {32{8'hA5}};
      bus.vc_rdata_exists = 1'b1;
      step();
      bus.vc_rdata_exists = 1'b0;
      wait_resp(10);
      chk("t2_hits", 256'(stat_hits), 256'(1));
      chk("t2_misses", 256'(stat_misses), 256'(0));

      // 3. Probe timeout, memory read, dirty victim written back.
      bus.l1_req = 1'b1;
      bus.l1_addr = 32'h3000_0100;
      bus.l1_evict = 1'b1;
      bus.l1_evict_addr = 32'h2000_0010;
      bus.l1_evict_data = {32{8'h5A}};
      bus.l1_evict_dirty = 1'b1;
      bus.pmem_rdata = {32{8'hC3}};
      sb_q.push_back('{line: {32{8'hC3}}, from_vc: 1'b0});
      step();
      for (int i = 0; i < 4; i++) begin
         chk("t3_probe_vc_read", 256'(bus.vc_read), 256'(1));
         chk("t3_probe_no_pmem", 256'(bus.pmem_read), 256'(0));
         step();
      end
      chk("t3_pmem_read1", 256'(bus.pmem_read), 256'(1));
      chk("t3_pmem_addr", 256'(bus.pmem_address), 256'(32'h3000_0100));
      chk("t3_no_vc_read", 256'(bus.vc_read), 256'(0));
      chk("t3_misses", 256'(stat_misses), 256'(1));
      bus.vc_rdata_exists = 1'b1;  // stray, must be ignored in MEM_RD
      step();
      bus.vc_rdata_exists = 1'b0;
      chk("t3_pmem_read2", 256'(bus.pmem_read), 256'(1));
      chk("t3_stray_hits", 256'(stat_hits), 256'(1));
      step();
      chk("t3_pmem_read3", 256'(bus.pmem_read), 256'(1));
      bus.pmem_resp = 1'b1;
      step();
      bus.pmem_resp = 1'b0;
      chk("t3_pmem_drop", 256'(bus.pmem_read), 256'(0));
      chk("t3_vc_write", 256'(bus.vc_write), 256'(1));
      chk("t3_vc_wr_addr", 256'(bus.vc_mem_address), 256'(32'h2000_0000));
      chk("t3_vc_wdata", bus.vc_mem_wdata, {32{8'h5A}});
      chk("t3_vc_dirty", 256'(bus.vc_is_dirty), 256'(1));
      step();
      chk("t3_vc_write_hold", 256'(bus.vc_write), 256'(1));
      chk("t3_no_read_write", 256'(bus.vc_read), 256'(0));
      bus.vc_rdata_exists = 1'b1;
      step();
      bus.vc_rdata_exists = 1'b0;
      bus.l1_evict = 1'b0;
      bus.l1_evict_dirty = 1'b0;
      wait_resp(10);
      chk("t3_end_misses", 256'(stat_misses), 256'(1));

      // 4. Hit arriving in the timeout cycle wins.
      bus.l1_req = 1'b1;
      bus.l1_addr = 32'h4000_0020;
      bus.vc_rdata = {32{8'h77}};
      sb_q.push_back('{line: {32{8'h77}}, from_vc: 1'b1});
      step();
      repeat (3) step();
      chk("t4_probe4", 256'(bus.vc_read), 256'(1));
      bus.vc_rdata_exists = 1'b1;
      step();
      bus.vc_rdata_exists = 1'b0;
      chk("t4_no_pmem", 256'(bus.pmem_read), 256'(0));
      wait_resp(10);
      chk("t4_hits", 256'(stat_hits), 256'(2));
      chk("t4_misses", 256'(stat_misses), 256'(1));

      // 5. Saturation of a 16-bit statistics counter.
      sat_inc = 1'b1;
      repeat (65534) step();
      chk("t5_near_max", 256'(sat_count), 256'(16'hFFFE));
      step();
      chk("t5_max", 256'(sat_count), 256'(16'hFFFF));
      step();
      chk("t5_hold", 256'(sat_count), 256'(16'hFFFF));
      sat_inc = 1'b0;

      // 6. Reset during MEM_RD abandons the transfer.
      bus.l1_req = 1'b1;
      bus.l1_addr = 32'h5000_0000;
      step();
      repeat (4) step();
      chk("t6_pmem_read", 256'(bus.pmem_read), 256'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_drop", 256'(bus.pmem_read), 256'(0));
      v32 = bus.pmem_address;
      chk("t6_addr_clear", 256'(v32), 256'(0));
      chk("t6_hits_clear", 256'(stat_hits), 256'(0));
      bus.l1_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      any_resp = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.l1_resp !== 1'b0) any_resp = 1'b1;
      end
      chk("t6_no_resp", 256'(any_resp), 256'(0));
      chk("sb_drained", 256'(sb_q.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
